egg_timer_sequencer: RTL and testbench
======================================

// Module: egg_timer_sequencer
// PURPOSE
//  Countdown datapath sequencer for the egg timer. Driven by the 3-bit controller state:
//   - loads minutes and seconds from the switches;
//   - counts down at 1 Hz while the controller is in TIMER;
//   - generates the 0.5 s cadence for the flash states;
//   - reports expiry so the controller leaves TIMER.
//  Sits between the controller FSM and the 7-segment/LED drivers.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency; half-second period = CLK_HZ/2 cycles
//  MAX_MIN  8'h99       BCD ceiling for minutes load (seconds ceiling fixed at 8'h59)
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  reset_n    in   1  asynchronous active-low reset
//  state      in   3  controller state: 4 RESET, 0 SET_SEC, 7 SETTING_MIN, 1 SET_MIN,
//                     3 READY, 2 TIMER, 5 FLASH_ON, 6 FLASH_OFF
//  set_val    in   8  two BCD digits {tens,units} from switches
//  min_bcd    out  8  current minutes, BCD
//  sec_bcd    out  8  current seconds, BCD
//  half_tick  out  1  one-cycle pulse every CLK_HZ/2 cycles while prescaler runs
//  done       out  1  level: state==TIMER and count==00:00
//  flash_led  out  1  registered LED drive, 1 only in FLASH_ON
// BEHAVIOUR
//  Reset (reset_n=0, async): min_bcd=0, sec_bcd=0, prescaler=0, half-phase=0,
//   half_tick=0, flash_led=0; done=0 as a consequence.
//  Prescaler: counts 0..CLK_HZ/2-1.
//   - Runs only in TIMER, FLASH_ON and FLASH_OFF; cleared to 0 in every other state.
//   - half_tick=1 in the cycle the count wraps.
//   - A 1-bit half-phase toggles on each half_tick; a second tick = half_tick with half-phase==1.
//   - Half-phase is cleared whenever the prescaler is cleared.
//  Per state:
//   RESET          min=sec=0.
//   SET_SEC        sec<=sanitize(set_val,8'h59) every cycle; min held.
//   SETTING_MIN    hold.
//   SET_MIN        min<=sanitize(set_val,MAX_MIN) every cycle; sec held.
//   READY          hold.
//   TIMER, on a second tick:
//     - sec!=0: sec<=sec-1 (BCD; units 0 -> 9 with tens-1);
//     - sec==0, min!=0: sec<=8'h59, min<=min-1 (BCD);
//     - 00:00: hold, no wrap.
//   FLASH_ON/OFF   count held at 00:00.
//  sanitize(v,ceil): result = ceil if either nibble >9 or v>ceil; otherwise v.
//  Latency:
//   - Count registers update on the clock edge ending the tick cycle.
//   - done is combinational from the registers, so it asserts the cycle the count shows 00:00.
//   - Entering TIMER at 00:00 gives done=1 in the first TIMER cycle.
//  flash_led <= (state==FLASH_ON), registered; it follows the state one cycle late.
//  Leaving TIMER mid-count (key[0] reset): the next RESET cycle clears the count and
//   prescaler. No partial second is carried over.
//  Re-entering TIMER: the prescaler starts from 0, so the first decrement comes exactly
//   CLK_HZ cycles later.
//  All 8 state encodings are defined; there is no illegal-state handling.
// CONFIGURATION
//  EGG_TIMER_PAUSE_EN defined:
//   - adds input port `pause` (1 bit, sync, active-high);
//   - in TIMER with pause=1, prescaler, half-phase and count all freeze; half_tick=0;
//   - done is still evaluated;
//   - releasing pause resumes from the frozen prescaler value.
//  Not defined: no pause port; the countdown is uninterruptible outside state changes.
// TESTING  (CLK_HZ overridden to 10 for simulation speed)
//  1. reset_n=0 mid-TIMER at 05:30 -> all outputs 0 immediately (async), before next clk edge.
//  2. SET_SEC set_val=8'h45, SET_MIN set_val=8'h02, TIMER 10 cycles -> 02:44;
//     a further 450 cycles -> 02:44 minus 45 s = 01:59.
//  3. SET_SEC set_val=8'h7A and 8'h63 -> sec_bcd=8'h59 in both cases.
//  4. Load 00:01, TIMER -> done=0 for cycles 0..9, done=1 from cycle 10; count holds 00:00.
//  5. Enter TIMER at 00:00 -> done=1 in first TIMER cycle.
//     Then FLASH_ON -> flash_led=1 one cycle later; half_tick every 5 cycles.
//  6. With EGG_TIMER_PAUSE_EN, from 01:00: pause for 30 cycles -> count stays 01:00, no half_tick;
//     release -> 00:59 after the remaining prescaler cycles.

Source files
------------

// File: rtl/egg_timer_sequencer.sv
// ============================================================================
// egg_timer_sequencer
// ----------------------------------------------------------------------------
// This is the countdown datapath for the egg timer. It sits between the
// controller FSM and the 7-segment/LED drivers. It works from the 3-bit
// controller state and does four jobs:
//   - loads minutes and seconds (BCD) from the switches, clamping bad values;
//   - counts down at 1 Hz while the controller is in TIMER;
//   - produces the 0.5 s cadence (half_tick) for the flash states;
//   - reports expiry (done) so the controller can leave TIMER.
//
// Optional feature macro: EGG_TIMER_PAUSE_EN
//   When this macro is defined, the design gets a synchronous active-high
//   `pause` input. While the state is TIMER and pause is high, the prescaler,
//   the half-phase and the count all freeze.
//
// Parameters
//   CLK_HZ   input clock frequency; one half-second is CLK_HZ/2 cycles
//   MAX_MIN  BCD ceiling for the minutes load (the seconds ceiling is 8'h59)
//
// Ports
//   clk        in   1  system clock, rising edge
//   reset_n    in   1  asynchronous active-low reset
//   state      in   3  controller state encoding (see state_e)
//   set_val    in   8  two BCD digits {tens,units} from the switches
//   pause      in   1  (EGG_TIMER_PAUSE_EN only) freeze the countdown in TIMER
//   min_bcd    out  8  current minutes, BCD (registered)
//   sec_bcd    out  8  current seconds, BCD (registered)
//   half_tick  out  1  one-cycle pulse each time the prescaler wraps
//   done       out  1  high while in TIMER with the count at 00:00
//   flash_led  out  1  LED drive, high only in FLASH_ON (registered)
// ============================================================================
module egg_timer_sequencer #(
    parameter int          CLK_HZ  = 50_000_000,
    parameter logic [7:0]  MAX_MIN = 8'h99
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  state,
    input  logic [7:0]  set_val,
`ifdef EGG_TIMER_PAUSE_EN
    input  logic        pause,
`endif
    output logic [7:0]  min_bcd,
    output logic [7:0]  sec_bcd,
    output logic        half_tick,
    output logic        done,
    output logic        flash_led
);

    // Controller state encodings. All eight codes are defined.
    typedef enum logic [2:0] {
        ST_SET_SEC     = 3'd0,
        ST_SET_MIN     = 3'd1,
        ST_TIMER       = 3'd2,
        ST_READY       = 3'd3,
        ST_RESET       = 3'd4,
        ST_FLASH_ON    = 3'd5,
        ST_FLASH_OFF   = 3'd6,
        ST_SETTING_MIN = 3'd7
    } state_e;

    localparam int          HALF     = CLK_HZ / 2;
    localparam int          PW       = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PW-1:0] HALF_MAX = PW'(HALF - 1);
    localparam logic [7:0]  SEC_CEIL = 8'h59;

    // Clamp a two-digit switch value to a BCD ceiling. A value is clamped if
    // either nibble is not a decimal digit, or if the value is above the ceiling.
    function automatic logic [7:0] sanitize(input logic [7:0] v, input logic [7:0] ceil);
        logic [7:0] r;
        if ((v[7:4] > 4'd9) || (v[3:0] > 4'd9) || (v > ceil)) begin
            r = ceil;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two-digit BCD decrement. Callers only use it on non-zero values.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    state_e         st_s;
    logic           run_s;
    logic           freeze_s;
    logic           tick_s;
    logic           second_s;
    logic           done_s;

    logic [PW-1:0]  presc_q, presc_d;
    logic           phase_q, phase_d;
    logic [7:0]     min_q,   min_d;
    logic [7:0]     sec_q,   sec_d;
    logic           flash_q, flash_d;

    // Decode the state and derive the prescaler strobes.
    always_comb begin
        st_s = state_e'(state);
        case (st_s)
            ST_TIMER, ST_FLASH_ON, ST_FLASH_OFF: run_s = 1'b1;
            default:                             run_s = 1'b0;
        endcase
`ifdef EGG_TIMER_PAUSE_EN
        freeze_s = (st_s == ST_TIMER) && pause;
`else
        freeze_s = 1'b0;
`endif
        tick_s   = run_s && !freeze_s && (presc_q == HALF_MAX);
        // The second edge is every other half tick, at the end of the second half.
        second_s = tick_s && phase_q;
    end

    // Half-second prescaler and half-phase. Both return to zero whenever the
    // prescaler stops, so each new TIMER entry starts on a whole-second boundary.
    always_comb begin
        presc_d = presc_q;
        phase_d = phase_q;
        if (!run_s) begin
            presc_d = {PW{1'b0}};
            phase_d = 1'b0;
        end else if (freeze_s) begin
            presc_d = presc_q;
            phase_d = phase_q;
        end else if (tick_s) begin
            presc_d = {PW{1'b0}};
            phase_d = ~phase_q;
        end else begin
            presc_d = presc_q + PW'(1);
            phase_d = phase_q;
        end
    end

    // Next-count logic: load from the switches, count down, or clear.
    always_comb begin
        min_d = min_q;
        sec_d = sec_q;
        case (st_s)
            ST_RESET: begin
                min_d = 8'h00;
                sec_d = 8'h00;
            end
            ST_SET_SEC: begin
                sec_d = sanitize(set_val, SEC_CEIL);
            end
            ST_SET_MIN: begin
                min_d = sanitize(set_val, MAX_MIN);
            end
            ST_TIMER: begin
                if (second_s) begin
                    if (sec_q != 8'h00) begin
                        sec_d = bcd_dec(sec_q);
                    end else if (min_q != 8'h00) begin
                        sec_d = SEC_CEIL;
                        min_d = bcd_dec(min_q);
                    end else begin
                        // Stay at 00:00; the count never wraps.
                        sec_d = sec_q;
                        min_d = min_q;
                    end
                end else begin
                    sec_d = sec_q;
                    min_d = min_q;
                end
            end
            ST_FLASH_ON, ST_FLASH_OFF: begin
                // The flash states only follow expiry, so the count is 00:00 here.
                min_d = 8'h00;
                sec_d = 8'h00;
            end
            default: begin
                min_d = min_q;
                sec_d = sec_q;
            end
        endcase
        flash_d = (st_s == ST_FLASH_ON);
    end

    // Expiry flag. It is taken straight from the count registers so it asserts
    // in the same cycle that 00:00 appears. It is also held low while reset
    // is asserted.
    always_comb begin
        done_s = reset_n && (st_s == ST_TIMER) && (min_q == 8'h00) && (sec_q == 8'h00);
    end

    // State registers for the sequencer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= {PW{1'b0}};
            phase_q <= 1'b0;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
            flash_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            phase_q <= phase_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            flash_q <= flash_d;
        end
    end

    assign min_bcd   = min_q;
    assign sec_bcd   = sec_q;
    assign half_tick = tick_s;
    assign done      = done_s;
    assign flash_led = flash_q;

endmodule

// File: tb/tb_egg_timer_sequencer.sv
module tb_egg_timer_sequencer;

    localparam logic [2:0] S_SET_SEC   = 3'd0;
    localparam logic [2:0] S_SET_MIN   = 3'd1;
    localparam logic [2:0] S_TIMER     = 3'd2;
    localparam logic [2:0] S_READY     = 3'd3;
    localparam logic [2:0] S_RESET     = 3'd4;
    localparam logic [2:0] S_FLASH_ON  = 3'd5;
    localparam logic [2:0] S_FLASH_OFF = 3'd6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  state;
    logic [7:0]  set_val;
    logic        pause;
    logic [7:0]  min_bcd;
    logic [7:0]  sec_bcd;
    logic        half_tick;
    logic        done;
    logic        flash_led;
    logic [18:0] obs;

    int vectors = 0;
    int misses  = 0;

    typedef struct {
        int          cyc;
        logic [18:0] v;
        string       name;
    } exp_t;

    exp_t sb[$];

    egg_timer_sequencer #(.CLK_HZ(10), .MAX_MIN(8'h99)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .state     (state),
        .set_val   (set_val),
`ifdef EGG_TIMER_PAUSE_EN
        .pause     (pause),
`endif
        .min_bcd   (min_bcd),
        .sec_bcd   (sec_bcd),
        .half_tick (half_tick),
        .done      (done),
        .flash_led (flash_led)
    );

    always #5 clk = ~clk;

    assign obs = {min_bcd, sec_bcd, done, flash_led, half_tick};

    task automatic push(input int c, input logic [7:0] m, input logic [7:0] s,
                        input logic d, input logic f, input logic t, input string n);
        exp_t e;
        e.cyc  = c;
        e.v    = {m, s, d, f, t};
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        sb.delete();
        push(0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "reset_idle");
        push(4, 8'h05, 8'h30, 1'b0, 1'b0, 1'b0, "timer_0530");
        push(5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "async_clear");
        push(6, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "after_reset");
        for (int c = 0; c <= 6; c++) begin
            case (c)
                0: begin reset_n = 1'b0; state = S_RESET; set_val = 8'h00; pause = 1'b0; end
                1: begin reset_n = 1'b1; state = S_SET_SEC; set_val = 8'h30; end
                2: begin state = S_SET_MIN; set_val = 8'h05; end
                3: state = S_READY;
                4: state = S_TIMER;
                5: reset_n = 1'b0;
                6: begin reset_n = 1'b1; state = S_RESET; end
                default: ;
            endcase
            #1;
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                vectors++;
                if (obs !== e.v) begin
                    misses++;
                    $display("FAIL %s @%0d: got min=%h sec=%h done=%b led=%b tick=%b, want min=%h sec=%h done=%b led=%b tick=%b",
                             e.name, c, obs[18:11], obs[10:3], obs[2], obs[1], obs[0],
                             e.v[18:11], e.v[10:3], e.v[2], e.v[1], e.v[0]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_load_count();
        exp_t e;
        sb.delete();
        push(3,   8'h02, 8'h45, 1'b0, 1'b0, 1'b0, "load_0245");
        push(7,   8'h02, 8'h45, 1'b0, 1'b0, 1'b1, "first_half");
        push(12,  8'h02, 8'h45, 1'b0, 1'b0, 1'b1, "second_edge");
        push(13,  8'h02, 8'h44, 1'b0, 1'b0, 1'b0, "after_10cyc");
        push(163, 8'h02, 8'h29, 1'b0, 1'b0, 1'b0, "after_16s");
        push(453, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, "at_0200");
        push(462, 8'h02, 8'h00, 1'b0, 1'b0, 1'b1, "pre_borrow");
        push(463, 8'h01, 8'h59, 1'b0, 1'b0, 1'b0, "borrow_0159");
        for (int c = 0; c <= 463; c++) begin
            case (c)
                0: begin state = S_SET_SEC; set_val = 8'h45; end
                1: begin state = S_SET_MIN; set_val = 8'h02; end
                2: state = S_READY;
                3: state = S_TIMER;
                default: ;
            endcase
            #1;
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                vectors++;
                if (obs !== e.v) begin
                    misses++;
                    $display("FAIL %s @%0d: got min=%h sec=%h done=%b led=%b tick=%b, want min=%h sec=%h done=%b led=%b tick=%b",
                             e.name, c, obs[18:11], obs[10:3], obs[2], obs[1], obs[0],
                             e.v[18:11], e.v[10:3], e.v[2], e.v[1], e.v[0]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sanitize();
        exp_t e;
        sb.delete();
        push(1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "reset_clear");
        push(2, 8'h00, 8'h59, 1'b0, 1'b0, 1'b0, "sec_7A");
        push(3, 8'h00, 8'h59, 1'b0, 1'b0, 1'b0, "sec_63");
        push(4, 8'h00, 8'h42, 1'b0, 1'b0, 1'b0, "sec_42");
        push(5, 8'h00, 8'h59, 1'b0, 1'b0, 1'b0, "sec_5A");
        push(6, 8'h99, 8'h59, 1'b0, 1'b0, 1'b0, "min_A0");
        push(7, 8'h37, 8'h59, 1'b0, 1'b0, 1'b0, "min_37");
        push(8, 8'h37, 8'h59, 1'b0, 1'b0, 1'b0, "ready_hold");
        for (int c = 0; c <= 8; c++) begin
            case (c)
                0: state = S_RESET;
                1: begin state = S_SET_SEC; set_val = 8'h7A; end
                2: set_val = 8'h63;
                3: set_val = 8'h42;
                4: set_val = 8'h5A;
                5: begin state = S_SET_MIN; set_val = 8'hA0; end
                6: set_val = 8'h37;
                7: begin state = S_READY; set_val = 8'h11; end
                default: ;
            endcase
            #1;
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                vectors++;
                if (obs !== e.v) begin
                    misses++;
                    $display("FAIL %s @%0d: got min=%h sec=%h done=%b led=%b tick=%b, want min=%h sec=%h done=%b led=%b tick=%b",
                             e.name, c, obs[18:11], obs[10:3], obs[2], obs[1], obs[0],
                             e.v[18:11], e.v[10:3], e.v[2], e.v[1], e.v[0]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_done();
        exp_t e;
        sb.delete();
        push(3,  8'h00, 8'h01, 1'b0, 1'b0, 1'b0, "load_0001");
        push(4,  8'h00, 8'h01, 1'b0, 1'b0, 1'b0, "timer_k0");
        push(13, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, "timer_k9");
        push(14, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, "done_k10");
        push(24, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, "hold_k20");
        push(33, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, "no_wrap_k29");
        push(34, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, "no_wrap_k30");
        for (int c = 0; c <= 34; c++) begin
            case (c)
                0: state = S_RESET;
                1: begin state = S_SET_SEC; set_val = 8'h01; end
                2: begin state = S_SET_MIN; set_val = 8'h00; end
                3: state = S_READY;
                4: state = S_TIMER;
                default: ;
            endcase
            #1;
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                vectors++;
                if (obs !== e.v) begin
                    misses++;
                    $display("FAIL %s @%0d: got min=%h sec=%h done=%b led=%b tick=%b, want min=%h sec=%h done=%b led=%b tick=%b",
                             e.name, c, obs[18:11], obs[10:3], obs[2], obs[1], obs[0],
                             e.v[18:11], e.v[10:3], e.v[2], e.v[1], e.v[0]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flash();
        exp_t e;
        sb.delete();
        push(1,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "ready_0000");
        push(2,  8'h00, 8'h00, 1'b1, 1'b0, 1'b0, "done_first_cyc");
        push(3,  8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "led_lag");
        push(4,  8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "led_on");
        push(6,  8'h00, 8'h00, 1'b0, 1'b1, 1'b1, "tick_a");
        push(7,  8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "tick_pulse");
        push(11, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, "tick_b");
        push(12, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "off_lag");
        push(13, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "led_off");
        push(16, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "tick_c");
        push(21, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, "tick_d");
        push(22, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "reset_no_tick");
        push(26, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "reset_stopped");
        for (int c = 0; c <= 26; c++) begin
            case (c)
                0:  state = S_RESET;
                1:  state = S_READY;
                2:  state = S_TIMER;
                3:  state = S_FLASH_ON;
                12: state = S_FLASH_OFF;
                22: state = S_RESET;
                default: ;
            endcase
            #1;
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                vectors++;
                if (obs !== e.v) begin
                    misses++;
                    $display("FAIL %s @%0d: got min=%h sec=%h done=%b led=%b tick=%b, want min=%h sec=%h done=%b led=%b tick=%b",
                             e.name, c, obs[18:11], obs[10:3], obs[2], obs[1], obs[0],
                             e.v[18:11], e.v[10:3], e.v[2], e.v[1], e.v[0]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sb.delete();
        push(10, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, "leave_mid");
        push(11, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "cleared");
        push(13, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, "reenter_k0");
        push(17, 8'h00, 8'h10, 1'b0, 1'b0, 1'b1, "reenter_k4");
        push(22, 8'h00, 8'h10, 1'b0, 1'b0, 1'b1, "reenter_k9");
        push(23, 8'h00, 8'h09, 1'b0, 1'b0, 1'b0, "reenter_k10");
        for (int c = 0; c <= 23; c++) begin
            case (c)
                0:  state = S_RESET;
                1:  begin state = S_SET_SEC; set_val = 8'h10; end
                2:  state = S_READY;
                3:  state = S_TIMER;
                10: state = S_RESET;
                11: state = S_SET_SEC;
                12: state = S_READY;
                13: state = S_TIMER;
                default: ;
            endcase
            #1;
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                vectors++;
                if (obs !== e.v) begin
                    misses++;
                    $display("FAIL %s @%0d: got min=%h sec=%h done=%b led=%b tick=%b, want min=%h sec=%h done=%b led=%b tick=%b",
                             e.name, c, obs[18:11], obs[10:3], obs[2], obs[1], obs[0],
                             e.v[18:11], e.v[10:3], e.v[2], e.v[1], e.v[0]);
                end
            end
            @(negedge clk);
        end
    endtask

`ifdef EGG_TIMER_PAUSE_EN
    task automatic test_pause();
        exp_t e;
        sb.delete();
        push(4,  8'h01, 8'h00, 1'b0, 1'b0, 1'b0, "start_0100");
        push(13, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, "pause_gates_tick");
        push(30, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, "paused_mid");
        push(42, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, "paused_end");
        push(43, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, "resume_tick");
        push(44, 8'h00, 8'h59, 1'b0, 1'b0, 1'b0, "resume_0059");
        for (int c = 0; c <= 44; c++) begin
            case (c)
                0:  state = S_RESET;
                1:  begin state = S_SET_SEC; set_val = 8'h00; end
                2:  begin state = S_SET_MIN; set_val = 8'h01; end
                3:  state = S_READY;
                4:  state = S_TIMER;
                13: pause = 1'b1;
                43: pause = 1'b0;
                default: ;
            endcase
            #1;
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front();
                vectors++;
                if (obs !== e.v) begin
                    misses++;
                    $display("FAIL %s @%0d: got min=%h sec=%h done=%b led=%b tick=%b, want min=%h sec=%h done=%b led=%b tick=%b",
                             e.name, c, obs[18:11], obs[10:3], obs[2], obs[1], obs[0],
                             e.v[18:11], e.v[10:3], e.v[2], e.v[1], e.v[0]);
                end
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        state   = S_RESET;
        set_val = 8'h00;
        pause   = 1'b0;
        test_reset();
        test_load_count();
        test_sanitize();
        test_done();
        test_flash();
        test_back_to_back();
`ifdef EGG_TIMER_PAUSE_EN
        test_pause();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
